// File: rtl/dmem_ctrl_if.sv
// Request/response bundle between the store-alignment stage and dmem_ctrl.
// The master drives requests and consumes responses; the slave is the controller.
interface dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        req_err;
  logic [2:0]  req_ldtype;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, req_err, req_ldtype, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, req_err, req_ldtype, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one request in flight, byte-lane stores, extended loads.
// Define DMEM_RANGE_CHECK_EN to reject addresses beyond DEPTH words instead of wrapping.
module dmem_ctrl #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input logic        clk,
  input logic        rst_n,
  dmem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          we_q;
  logic          err_q;
  logic [AW-1:0] idx_q;
  logic [1:0]    off_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [2:0]    ldtype_q;

  logic          req_ready_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_rdata_q;

  logic [31:0]   mem [DEPTH];

  logic [31-(AW+2):0] addr_hi;
  logic               ldtype_ok;
  logic               range_err;
  logic               acc_err;

  assign addr_hi = bus.req_addr[31:AW+2];

`ifdef DMEM_RANGE_CHECK_EN
  assign range_err = |addr_hi;
`else
  // Upper address bits are dropped so accesses wrap modulo DEPTH words.
  assign range_err = 1'b0;
  logic unused_addr_hi;
  assign unused_addr_hi = ^addr_hi;
`endif

  always_comb begin
    ldtype_ok = 1'b0;
    case (bus.req_ldtype)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: ldtype_ok = 1'b1;
      default:                                ldtype_ok = 1'b0;
    endcase
  end

  always_comb begin
    acc_err = bus.req_err
            | (bus.req_we & (bus.req_be == 4'b0000))
            | (~bus.req_we & ~ldtype_ok)
            | range_err;
  end

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] off,
                                         input logic [2:0] lt);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (lt)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b010:  extend = w;
      3'b100:  extend = {24'h0, b};
      3'b101:  extend = {16'h0, h};
      default: extend = '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      off_q       <= '0;
      be_q        <= '0;
      wdata_q     <= '0;
      ldtype_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            we_q        <= bus.req_we;
            err_q       <= acc_err;
            idx_q       <= bus.req_addr[AW+1:2];
            off_q       <= bus.req_addr[1:0];
            be_q        <= bus.req_be;
            wdata_q     <= bus.req_wdata;
            ldtype_q    <= bus.req_ldtype;
            req_ready_q <= 1'b0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= err_q;
          rsp_rdata_q <= (!we_q && !err_q) ? extend(mem[idx_q], off_q, ldtype_q) : '0;
          state       <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory is not reset; a reset mid-store forces IDLE asynchronously, so the write is dropped.
  always_ff @(posedge clk) begin
    if (state == ACCESS && we_q && !err_q) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: stores, extended loads, error paths, backpressure, reset.
module tb_dmem_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  dmem_ctrl_if bus ();

  dmem_ctrl #(.DEPTH(1024), .AW(10)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one request, returns #1 after the accepting edge with inputs scrambled.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic e, input logic [2:0] lt);
    @(negedge clk);
    chk("req_ready_idle", {31'h0, bus.req_ready}, 32'h1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_be     = be;
    bus.req_wdata  = wd;
    bus.req_err    = e;
    bus.req_ldtype = lt;
    @(posedge clk);
    #1;
    bus.req_valid  = 1'b0;
    bus.req_we     = ~we;
    bus.req_addr   = 32'hDEAD_BEEF;
    bus.req_be     = 4'hF;
    bus.req_wdata  = 32'hFFFF_FFFF;
    bus.req_err    = 1'b0;
    bus.req_ldtype = 3'b111;
    chk("no_rsp_on_accept", {31'h0, bus.rsp_valid}, 32'h0);
  endtask

  task automatic xact(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input logic e, input logic [2:0] lt,
                      output logic [31:0] rd, output logic re);
    int n;
    issue(we, addr, be, wd, e, lt);
    n = 0;
    while (!bus.rsp_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("rsp_latency", n, 32'd1);
    rd = bus.rsp_rdata;
    re = bus.rsp_err;
    @(posedge clk);
    #1;
    chk("rsp_drop_after_hs", {31'h0, bus.rsp_valid}, 32'h0);
    chk("ready_after_hs", {31'h0, bus.req_ready}, 32'h1);
  endtask

  task automatic store(input string tag, input logic [31:0] addr, input logic [3:0] be,
                       input logic [31:0] wd, input logic e, input logic exp_err);
    logic [31:0] rd;
    logic        re;
    xact(1'b1, addr, be, wd, e, 3'b010, rd, re);
    chk({tag, "_err"}, {31'h0, re}, {31'h0, exp_err});
    chk({tag, "_rdata"}, rd, 32'h0);
  endtask

  task automatic load(input string tag, input logic [31:0] addr, input logic [2:0] lt,
                      input logic e, input logic [31:0] exp_rd, input logic exp_err);
    logic [31:0] rd;
    logic        re;
    xact(1'b0, addr, 4'h0, 32'h0, e, lt, rd, re);
    chk({tag, "_err"}, {31'h0, re}, {31'h0, exp_err});
    chk({tag, "_rdata"}, rd, exp_rd);
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_be     = '0;
    bus.req_wdata  = '0;
    bus.req_err    = 1'b0;
    bus.req_ldtype = '0;
    bus.rsp_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Word store and readback
    store("sw_10", 32'h10, 4'b1111, 32'h1122_3344, 1'b0, 1'b0);
    load("lw_10", 32'h10, 3'b010, 1'b0, 32'h1122_3344, 1'b0);

    // Byte store into lane 2
    store("sb_12", 32'h12, 4'b0100, 32'h00AB_0000, 1'b0, 1'b0);
    load("lb_12", 32'h12, 3'b000, 1'b0, 32'hFFFF_FFAB, 1'b0);
    load("lbu_12", 32'h12, 3'b100, 1'b0, 32'h0000_00AB, 1'b0);
    load("lw_10b", 32'h10, 3'b010, 1'b0, 32'h11AB_3344, 1'b0);
    load("lb_11", 32'h11, 3'b000, 1'b0, 32'h0000_0033, 1'b0);
    load("lh_10", 32'h10, 3'b001, 1'b0, 32'h0000_3344, 1'b0);

    // Halfword store into upper lanes
    store("sh_02", 32'h02, 4'b1100, 32'h8001_0000, 1'b0, 1'b0);
    load("lh_02", 32'h02, 3'b001, 1'b0, 32'hFFFF_8001, 1'b0);
    load("lhu_02", 32'h02, 3'b101, 1'b0, 32'h0000_8001, 1'b0);

    // Error paths leave memory untouched
    store("sw_misal", 32'h10, 4'b1111, 32'hFFFF_FFFF, 1'b1, 1'b1);
    load("lw_after_misal", 32'h10, 3'b010, 1'b0, 32'h11AB_3344, 1'b0);
    store("sw_be0", 32'h10, 4'b0000, 32'h0000_0000, 1'b0, 1'b1);
    load("lw_after_be0", 32'h10, 3'b010, 1'b0, 32'h11AB_3344, 1'b0);
    load("ld_bad_type", 32'h10, 3'b011, 1'b0, 32'h0, 1'b1);
    load("ld_misal", 32'h10, 3'b010, 1'b1, 32'h0, 1'b1);
    load("lw_after_errs", 32'h10, 3'b010, 1'b0, 32'h11AB_3344, 1'b0);

    // Backpressure: response held stable while rsp_ready is low
    bus.rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 3'b010);
    @(posedge clk);
    #1;
    chk("bp_valid_rise", {31'h0, bus.rsp_valid}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_valid_hold", {31'h0, bus.rsp_valid}, 32'h1);
      chk("bp_rdata_hold", bus.rsp_rdata, 32'h11AB_3344);
      chk("bp_err_hold", {31'h0, bus.rsp_err}, 32'h0);
      chk("bp_ready_low", {31'h0, bus.req_ready}, 32'h0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_hs_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("bp_hs_ready", {31'h0, bus.req_ready}, 32'h1);

`ifdef DMEM_RANGE_CHECK_EN
    store("sw_oor", 32'h0000_1010, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b1);
    load("lw_oor", 32'h0000_1010, 3'b010, 1'b0, 32'h0, 1'b1);
    load("lw_after_oor", 32'h10, 3'b010, 1'b0, 32'h11AB_3344, 1'b0);
`else
    store("sw_wrap", 32'h0000_1010, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0);
    load("lw_wrap_lo", 32'h10, 3'b010, 1'b0, 32'hCAFE_F00D, 1'b0);
    load("lw_wrap_hi", 32'hFFFF_F010, 3'b010, 1'b0, 32'hCAFE_F00D, 1'b0);
`endif

    // Reset during ACCESS of a store drops the write
    store("sw_20", 32'h20, 4'b1111, 32'h5555_AAAA, 1'b0, 1'b0);
    issue(1'b1, 32'h20, 4'b1111, 32'h1234_5678, 1'b0, 3'b010);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("midrst_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("midrst_rdata", bus.rsp_rdata, 32'h0);
    chk("midrst_err", {31'h0, bus.rsp_err}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    load("lw_after_rst", 32'h20, 3'b010, 1'b0, 32'h5555_AAAA, 1'b0);
    load("lw_10_kept", 32'h10, 3'b001, 1'b0,
`ifdef DMEM_RANGE_CHECK_EN
         32'h0000_3344,
`else
         32'hFFFF_F00D,
`endif
         1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory controller that sits directly downstream of the store-alignment stage. It takes an already lane-shifted byte-enable mask, write data and misalignment flag, and performs the access on an internal word-addressed memory with a valid/ready request and response handshake. For loads it extracts and sign- or zero-extends the addressed byte, halfword or word. Misaligned, malformed or out-of-range accesses return an error response without touching memory.

## Interface
Parameters:
- DEPTH, 1024, number of 32-bit words in the memory
- AW, 10, word-index width; DEPTH must equal 2**AW

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_be  in  4  lane byte enables, already shifted to the addressed lanes
- req_wdata  in  32  store data, already lane-shifted
- req_err  in  1  misalignment flag from the alignment stage
- req_ldtype  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access was rejected

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. If req_valid is high, the controller latches we, addr, be, wdata, ldtype and the computed error, then moves to ACCESS.
- Error computation at acceptance is the OR of:
  - req_err;
  - a store with be=0000;
  - a load with an ldtype outside the five legal codes;
  - out-of-range address (see Configuration).
- ACCESS: performed for one cycle, then the FSM moves to RESP.
  - Store without error: writes each byte lane i where be[i]=1, at word index addr[AW+1:2]. Lanes with be[i]=0 are unchanged.
  - Load without error: reads the word synchronously.
  - Error: no memory write in either case.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_valid & rsp_ready; then the FSM returns to IDLE.
- Load extraction uses the latched addr[1:0]:
  - LB/LBU: byte at lane addr[1:0].
  - LH/LHU: halfword at lane pair addr[1].
  - LW: full word.
  - LB and LH sign-extend to 32 bits; LBU and LHU zero-extend.
- req_addr[31:AW+2] is ignored for indexing.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: FSM=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Request accepted at rising edge E0 (IDLE & req_valid).
- The memory write or read happens at edge E1.
- rsp_valid is high from E1 until the handshake edge. Minimum latency from acceptance to rsp_valid is one cycle.
- req_ready is 0 in ACCESS and RESP. Peak throughput is one request per 3 cycles when rsp_ready is held at 1.
- A stalled response (rsp_ready=0) holds all rsp_* outputs unchanged for any number of cycles.
- Request inputs may change freely after acceptance; only the latched copies are used.
- Reset asserted mid-operation: outputs return immediately to their reset values and the FSM goes to IDLE.
  - A store still in IDLE or ACCESS before edge E1 is dropped; no memory write occurs.
  - Memory locations already written keep their contents.
- rsp_valid never asserts on the same cycle a request is accepted.

## Configuration
- DMEM_RANGE_CHECK_EN defined:
  - req_addr[31:AW+2] must be zero; otherwise the access is an error (rsp_err=1, no write, rsp_rdata=0).
- DMEM_RANGE_CHECK_EN undefined:
  - Upper address bits are ignored and addresses wrap modulo DEPTH words.
  - Error then comes only from req_err, a store with be=0 or an illegal ldtype.

## Test plan
- Store then load: store wdata=0x11223344, be=1111 at addr 0x10, then LW at 0x10 -> rsp_rdata=0x11223344, rsp_err=0, rsp_valid one cycle after each acceptance.
- Byte store: store be=0100, wdata=0x00AB0000 at 0x12 over 0x11223344. Then:
  - LB at 0x12 -> 0xFFFFFFAB.
  - LBU at 0x12 -> 0x000000AB.
  - LW at 0x10 -> 0x11AB3344.
- Halfword store: store be=1100, wdata=0x80010000 at 0x02. Then:
  - LH at 0x02 -> 0xFFFF8001.
  - LHU at 0x02 -> 0x00008001.
- Error paths: each of the following returns rsp_err=1 and rsp_rdata=0, and a following LW of the same word shows it unchanged:
  - req_err=1;
  - ldtype=011;
  - with DMEM_RANGE_CHECK_EN, addr 0x0000_1000 at DEPTH=1024.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid rises -> rsp_* stable and req_ready=0 throughout. Raising rsp_ready gives a handshake on that edge and req_ready=1 on the next cycle.
- Reset mid-op: assert rst_n=0 in ACCESS of a store to 0x20 -> rsp_valid=0 and req_ready=1 immediately. After release, LW 0x20 returns the prior contents.
